vga_scan: RTL and testbench
===========================

# vga_scan

Raster timing generator and pixel sink for the 640×480@60 Hz VGA output. It drives `h_addr`/`v_addr` to every screen layer (welcome screen, text terminal, game layers) and accepts their 24-bit colour. It realigns sync and blanking with the layers' memory read latency and emits the DAC-side RGB and sync signals. It runs on the 50 MHz system clock with an internal pixel-rate enable.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel tick; must be at least 1.
- `RGB_LAT`, 1: pixel ticks between an address and valid `rgb_in`; range 0..4.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal segments, in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical segments, in lines.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `rgb_in` in 24: colour from the selected layer, `{R,G,B}`.
- `h_addr` out 10: current pixel column.
- `v_addr` out 10: current line.
- `pix_ce` out 1: one-clk pulse on each pixel tick.
- `frame_start` out 1: one-clk pulse at the start of each frame.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `blank_n` out 1: high during the active video region.
- `vga_r`, `vga_g`, `vga_b` out 8 each: DAC colour.
- `frame_cnt` out 16: frame counter; exists only with the configuration macro.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_ce` is registered and is 1 on the clock after `div_cnt == CLK_DIV-1`.
  - With `CLK_DIV == 1`, `pix_ce` is constantly 1 after reset.
- Horizontal counter `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = 800. It advances only on tick cycles.
- Vertical counter `v_cnt` counts 0..V_TOTAL-1, where V_TOTAL = 525. It advances on the tick where `h_cnt` wraps from 799 to 0.
- After line 524, pixel 799, both counters return to 0.
- `h_addr = h_cnt`, `v_addr = v_cnt`, always, including blanking.
  - Layers must treat `v_addr >= 480` or `h_addr >= 640` as off-screen.
- Raw active region: `h_cnt < H_ACTIVE && v_cnt < V_ACTIVE`.
- Raw hsync is low for `h_cnt` in [656, 751].
- Raw vsync is low for `v_cnt` in [490, 491].
- Raw active, hsync and vsync pass through an `RGB_LAT`-stage shift register clocked on ticks, and become `blank_n`, `hsync`, `vsync`.
- Colour output:
  - When the delayed `blank_n` is 1, `{vga_r,vga_g,vga_b}` takes `rgb_in`, registered on a tick.
  - Otherwise it is 0.
- `frame_start` is a one-clk pulse, coincident with `pix_ce`, on the tick where the counters become (0,0). It is undelayed.
- No other state machine: the raster runs continuously and has no stall or handshake input.

## Timing
- Reset values, held while `rst` is high:
  - `div_cnt`, `h_cnt`, `v_cnt` = 0, so `h_addr` = `v_addr` = 0.
  - `pix_ce` = 0, `frame_start` = 0, `blank_n` = 0, RGB = 0.
  - `hsync` = 1, `vsync` = 1.
  - Every shift-register stage is set to the inactive value.
- First tick after release:
  - It occurs on the CLK_DIV-th rising clock edge.
  - It advances the counters to (1,0).
  - Pixel (0,0) is therefore presented for CLK_DIV clocks straight out of reset; no `frame_start` is emitted for it.
- `frame_start` first occurs at the wrap to (0,0) after line 524.
- Latency: `blank_n`, `hsync`, `vsync` and RGB lag `h_addr`/`v_addr` by exactly `RGB_LAT` ticks.
  - With `RGB_LAT = 0`, the registered outputs lag by one tick only.
- All outputs are registered and change only on tick edges. The exceptions are `pix_ce` and `frame_start`, which are single-clk pulses.
- Asynchronous `rst` mid-frame immediately forces the reset values, including while a sync pulse is active.
- Parameters are fixed at elaboration. Segment sums above 1023 are illegal.

## Configuration
- `VGA_SCAN_FRAME_CNT_EN` defined:
  - `frame_cnt` is a 16-bit counter, reset to 0.
  - It increments on each `frame_start` and wraps from 65535 to 0.
  - Animation layers use it as a frame time base.
- Undefined: the port still exists, is tied to 0, and no counter is built.

## Test plan
- Reset with `CLK_DIV=2`:
  - Hold `rst` for 5 clks, then release.
  - `hsync = vsync = 1` and `blank_n = 0` during reset.
  - The first `pix_ce` arrives 2 clks after release.
  - `h_addr` steps 0→1 on that tick.
- Line timing:
  - Over 800 ticks, `blank_n` is high for exactly 640 ticks per active line.
  - `hsync` is low for exactly 96 ticks, starting `RGB_LAT` ticks after `h_addr == 656`.
- Frame timing:
  - `frame_start` pulses exactly every 420000 ticks (840000 clks).
  - `vsync` is low for exactly 1600 ticks per frame, starting when `v_addr == 490` (plus latency).
- Latency alignment with `RGB_LAT=1`:
  - Drive `rgb_in = {h_addr[7:0], v_addr[7:0], 8'hA5}` one tick late.
  - The sampled output at pixel (5,7) is `24'h0507A5`.
  - The output is 0 while `blank_n = 0`.
- Mid-frame reset:
  - Assert `rst` at `v_addr=491`, `h_addr=700`.
  - Outputs immediately take reset values.
  - After release, the counters restart from (0,0).
- Macro `VGA_SCAN_FRAME_CNT_EN`:
  - Defined: after 3 `frame_start` pulses, `frame_cnt == 3`.
  - Undefined: `frame_cnt` stays 0 throughout.

Source files
------------

// File: rtl/vga_scan.sv
// vga_scan: 640x480@60 raster timing generator and pixel sink.
// Counts pixels/lines on a divided pixel tick, presents h_addr/v_addr to the
// screen layers, and delays blank/sync to line up with the layers' colour.
// Optional feature macro: VGA_SCAN_FRAME_CNT_EN (builds the 16-bit frame_cnt).
module vga_scan #(
    parameter int CLK_DIV  = 2,
    parameter int RGB_LAT  = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb_in,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        pix_ce,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // A layer with no read latency still costs one tick through the colour
    // register, so the alignment pipe is never shorter than one stage.
    localparam int DLY     = (RGB_LAT < 1) ? 1 : RGB_LAT;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [9:0]       h_cnt, v_cnt;
    logic             raw_act, raw_hs, raw_vs;
    logic [DLY:1]     act_sr, hs_sr, vs_sr;
    logic [DLY:0]     act_tap, hs_tap, vs_tap;
    logic [23:0]      rgb_q;

    assign tick = (div_cnt == DIV_LAST);

    // Pixel-rate divider: wraps at CLK_DIV-1, which is the tick cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // pix_ce marks the clock right after each tick edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pix_ce <= 1'b0;
        else     pix_ce <= tick;
    end

    // Raster counters; the line counter steps when the pixel counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Frame pulse on the tick that lands the counters on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_start <= 1'b0;
        else     frame_start <= tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

    assign h_addr = h_cnt;
    assign v_addr = v_cnt;

    assign raw_act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign raw_hs  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign raw_vs  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

    // Tap vectors: index 0 is the undelayed raw value, index i is i ticks old.
    always_comb begin
        act_tap = {act_sr, raw_act};
        hs_tap  = {hs_sr, raw_hs};
        vs_tap  = {vs_sr, raw_vs};
    end

    // Alignment pipe for blank/sync plus the colour register, all on ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_sr <= '0;
            hs_sr  <= '1;
            vs_sr  <= '1;
            rgb_q  <= '0;
        end else if (tick) begin
            act_sr <= act_tap[DLY-1:0];
            hs_sr  <= hs_tap[DLY-1:0];
            vs_sr  <= vs_tap[DLY-1:0];
            rgb_q  <= act_tap[DLY-1] ? rgb_in : 24'd0;
        end
    end

    assign blank_n = act_sr[DLY];
    assign hsync   = hs_sr[DLY];
    assign vsync   = vs_sr[DLY];
    assign {vga_r, vga_g, vga_b} = rgb_q;

`ifdef VGA_SCAN_FRAME_CNT_EN
    logic [15:0] frame_q;

    // Free-running frame time base for animation layers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              frame_q <= '0;
        else if (frame_start) frame_q <= frame_q + 16'd1;
    end

    assign frame_cnt = frame_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan on a shrunken raster (30x17 total) so whole
// frames fit in a short run. Active 16x10, hsync low for h in [20,25],
// vsync low for v in [12,13], CLK_DIV=2, RGB_LAT=1.
module tb_vga_scan;

    localparam int CD = 2;

    logic        clk, rst;
    logic [23:0] rgb_in;
    logic [9:0]  h_addr, v_addr;
    logic        pix_ce, frame_start, hsync, vsync, blank_n;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [15:0] frame_cnt;
    logic [23:0] rgb_out;

    int n_cmp = 0;
    int n_bad = 0;

    vga_scan #(
        .CLK_DIV(CD), .RGB_LAT(1),
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in),
        .h_addr(h_addr), .v_addr(v_addr), .pix_ce(pix_ce),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait layer model: colour follows the address, captured next tick.
    always_comb rgb_in = {h_addr[7:0], v_addr[7:0], 8'hA5};
    assign rgb_out = {vga_r, vga_g, vga_b};

    task automatic step_tick();
        repeat (CD) @(negedge clk);
    endtask

    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        while (!(h_addr == 10'(h) && v_addr == 10'(v)) && n < 1200) begin
            step_tick();
            n++;
        end
        n_cmp++;
        if (n >= 1200) begin
            n_bad++;
            $display("FAIL goto: position (%0d,%0d) never reached, at (%0d,%0d)", h, v, h_addr, v_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (h_addr !== 10'd0 || v_addr !== 10'd0) begin n_bad++; $display("FAIL rst_addr: got (%0d,%0d) exp (0,0)", h_addr, v_addr); end
        n_cmp++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_bad++; $display("FAIL rst_sync: got hs=%b vs=%b exp 1 1", hsync, vsync); end
        n_cmp++; if (blank_n !== 1'b0 || rgb_out !== 24'd0) begin n_bad++; $display("FAIL rst_blank: got blank_n=%b rgb=%h exp 0 0", blank_n, rgb_out); end
        n_cmp++; if (pix_ce !== 1'b0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_pulse: got ce=%b fs=%b exp 0 0", pix_ce, frame_start); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_fcnt: got %0d exp 0", frame_cnt); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (pix_ce !== 1'b0 || h_addr !== 10'd0) begin n_bad++; $display("FAIL first_clk: got ce=%b h=%0d exp 0 0", pix_ce, h_addr); end
        @(negedge clk);
        n_cmp++; if (pix_ce !== 1'b1 || h_addr !== 10'd1 || v_addr !== 10'd0) begin n_bad++; $display("FAIL first_tick: got ce=%b h=%0d v=%0d exp 1 1 0", pix_ce, h_addr, v_addr); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL first_fs: got %b exp 0", frame_start); end
        n_cmp++; if (blank_n !== 1'b1 || rgb_out !== 24'h0000A5) begin n_bad++; $display("FAIL first_pix: got blank_n=%b rgb=%h exp 1 0000a5", blank_n, rgb_out); end
        @(negedge clk);
        n_cmp++; if (pix_ce !== 1'b0) begin n_bad++; $display("FAIL ce_width: got %b exp 0", pix_ce); end
        @(negedge clk);
    endtask

    task automatic test_line();
        int act_n, hs_n, first_h;
        goto(0, 2);
        act_n = 0; hs_n = 0; first_h = -1;
        for (int i = 0; i < 30; i++) begin
            if (blank_n === 1'b1) act_n++;
            if (hsync === 1'b0) begin
                if (first_h < 0) first_h = int'(h_addr);
                hs_n++;
            end
            step_tick();
        end
        n_cmp++; if (act_n !== 16) begin n_bad++; $display("FAIL line_active: got %0d exp 16", act_n); end
        n_cmp++; if (hs_n !== 6) begin n_bad++; $display("FAIL hsync_width: got %0d exp 6", hs_n); end
        n_cmp++; if (first_h !== 21) begin n_bad++; $display("FAIL hsync_start: got h=%0d exp 21", first_h); end
        goto(0, 11);
        act_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (blank_n === 1'b1) act_n++;
            step_tick();
        end
        n_cmp++; if (act_n !== 0) begin n_bad++; $display("FAIL vblank_line: got %0d exp 0", act_n); end
    endtask

    task automatic test_frame();
        int n, vs_n, vs_h, vs_v;
        goto(0, 0);
        n_cmp++; if (frame_start !== 1'b1 || pix_ce !== 1'b1) begin n_bad++; $display("FAIL fs_pulse: got fs=%b ce=%b exp 1 1", frame_start, pix_ce); end
        @(negedge clk);
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL fs_width: got %b exp 0", frame_start); end
        @(negedge clk);
        n = 1; vs_n = 0; vs_h = -1; vs_v = -1;
        while (frame_start !== 1'b1 && n < 600) begin
            if (vsync === 1'b0) begin
                if (vs_h < 0) begin vs_h = int'(h_addr); vs_v = int'(v_addr); end
                vs_n++;
            end
            step_tick();
            n++;
        end
        n_cmp++; if (n !== 510) begin n_bad++; $display("FAIL frame_period: got %0d ticks exp 510", n); end
        n_cmp++; if (vs_n !== 60) begin n_bad++; $display("FAIL vsync_width: got %0d exp 60", vs_n); end
        n_cmp++; if (vs_h !== 1 || vs_v !== 12) begin n_bad++; $display("FAIL vsync_start: got (%0d,%0d) exp (1,12)", vs_h, vs_v); end
    endtask

    task automatic test_latency();
        goto(6, 7);
        n_cmp++; if (blank_n !== 1'b1 || rgb_out !== 24'h0507A5) begin n_bad++; $display("FAIL pix_5_7: got blank_n=%b rgb=%h exp 1 0507a5", blank_n, rgb_out); end
        goto(16, 3);
        n_cmp++; if (blank_n !== 1'b1 || rgb_out !== 24'h0F03A5) begin n_bad++; $display("FAIL pix_last: got blank_n=%b rgb=%h exp 1 0f03a5", blank_n, rgb_out); end
        step_tick();
        n_cmp++; if (blank_n !== 1'b0 || rgb_out !== 24'd0) begin n_bad++; $display("FAIL hblank_rgb: got blank_n=%b rgb=%h exp 0 0", blank_n, rgb_out); end
        goto(1, 10);
        n_cmp++; if (blank_n !== 1'b0 || rgb_out !== 24'd0) begin n_bad++; $display("FAIL vblank_rgb: got blank_n=%b rgb=%h exp 0 0", blank_n, rgb_out); end
    endtask

    task automatic test_mid_reset();
        goto(22, 13);
        n_cmp++; if (hsync !== 1'b0 || vsync !== 1'b0) begin n_bad++; $display("FAIL pre_rst_sync: got hs=%b vs=%b exp 0 0", hsync, vsync); end
        rst = 1'b1;
        #1;
        n_cmp++; if (h_addr !== 10'd0 || v_addr !== 10'd0) begin n_bad++; $display("FAIL mid_rst_addr: got (%0d,%0d) exp (0,0)", h_addr, v_addr); end
        n_cmp++; if (hsync !== 1'b1 || vsync !== 1'b1 || blank_n !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sync: got hs=%b vs=%b bl=%b exp 1 1 0", hsync, vsync, blank_n); end
        n_cmp++; if (pix_ce !== 1'b0 || rgb_out !== 24'd0) begin n_bad++; $display("FAIL mid_rst_out: got ce=%b rgb=%h exp 0 0", pix_ce, rgb_out); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (CD) @(negedge clk);
        n_cmp++; if (h_addr !== 10'd1 || v_addr !== 10'd0 || pix_ce !== 1'b1) begin n_bad++; $display("FAIL restart: got (%0d,%0d) ce=%b exp (1,0) 1", h_addr, v_addr, pix_ce); end
    endtask

    task automatic test_frame_cnt();
        int fs_n, n;
        logic [15:0] exp_cnt;
        fs_n = 0; n = 0;
        while (fs_n < 3 && n < 1700) begin
            step_tick();
            n++;
            if (frame_start === 1'b1) fs_n++;
        end
        n_cmp++; if (fs_n !== 3) begin n_bad++; $display("FAIL fs_count: got %0d pulses exp 3", fs_n); end
        step_tick();
`ifdef VGA_SCAN_FRAME_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        n_cmp++; if (frame_cnt !== exp_cnt) begin n_bad++; $display("FAIL frame_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_line();
        test_frame();
        test_latency();
        test_mid_reset();
        test_frame_cnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
